// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding an 8N1 UART transmitter.
// Latency: start bit on TX the cycle after acceptance; a frame lasts 10*BIT_PERIOD cycles.
// Backpressure: req0_ready/req1_ready stay low while a frame is in progress.
module uart_tx_arbiter #(
    parameter int BAUD_RATE     = 9600,
    parameter int CLOCK_FREQ_HZ = 12000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       TX,
    output logic       busy,
    output logic [1:0] grant
);

    localparam int BIT_PERIOD = CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] BP_LAST = CNT_W'(BIT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             tx_q;
    logic [1:0]       grant_q;
    logic             last;
    logic             sel;
    logic             xfer;
    logic             bit_end;

    // sel: 1 picks requester 1; contention goes to whoever was not served last
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
            sel = ~last;
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end

    assign req0_ready = resetn && (state == IDLE) && req0_valid && !sel;
    assign req1_ready = resetn && (state == IDLE) && req1_valid && sel;
    assign xfer       = req0_ready || req1_ready;
    assign bit_end    = (cnt == BP_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (xfer) state_next = START;
            START: if (bit_end) state_next = DATA;
            DATA:  if (bit_end && (bit_idx == 3'd7)) state_next = STOP;
            STOP:  if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_q    <= 1'b1;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            grant_q <= 2'b00;
            last    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= 3'd0;
                    if (xfer) begin
                        shreg   <= sel ? req1_data : req0_data;
                        grant_q <= sel ? 2'b10 : 2'b01;
                        last    <= sel;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt  <= '0;
                        tx_q <= shreg[0];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            tx_q    <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    // TX is already high from the stop bit, which is also the idle level
                    if (bit_end) begin
                        cnt     <= '0;
                        grant_q <= 2'b00;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt  <= '0;
                    tx_q <= 1'b1;
                end
            endcase
        end
    end

    assign TX    = tx_q;
    assign busy  = (state != IDLE);
    assign grant = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at BIT_PERIOD=10; inputs change and outputs are sampled 1ns after the rising edge.
module tb_uart_tx_arbiter;

    logic       clk;
    logic       resetn;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       TX;
    logic       busy;
    logic [1:0] grant;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_arbiter #(
        .BAUD_RATE(1200000),
        .CLOCK_FREQ_HZ(12000000)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .req0_valid(req0_valid),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .TX(TX),
        .busy(busy),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester hold obligation: once waiting, valid and data stay put until accepted
    logic       hold_en = 1'b0;
    logic       wait0_q = 1'b0;
    logic       wait1_q = 1'b0;
    logic [7:0] d0_q = 8'h00;
    logic [7:0] d1_q = 8'h00;
    always @(posedge clk) begin
        if (hold_en && wait0_q)
            assert (req0_valid && req0_data == d0_q) else $error("req0 dropped a pending request");
        if (hold_en && wait1_q)
            assert (req1_valid && req1_data == d1_q) else $error("req1 dropped a pending request");
        wait0_q <= req0_valid && !req0_ready;
        wait1_q <= req1_valid && !req1_ready;
        d0_q    <= req0_data;
        d1_q    <= req1_data;
    end

    function automatic logic exp_tx(input logic [7:0] d, input int i);
        if (i < 10) return 1'b0;
        if (i < 90) return d[(i - 10) / 10];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered 1ns after the accepting edge plus 'first' cycles; checks 'n' frame cycles
    task automatic frame_check(input logic [7:0] d, input logic [1:0] g, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            chk($sformatf("tx[%0d]", i), 32'(TX), 32'(exp_tx(d, i)));
            chk("busy_in_frame", 32'(busy), 32'd1);
            chk("grant_in_frame", 32'(grant), 32'(g));
            chk("rdy0_in_frame", 32'(req0_ready), 32'd0);
            chk("rdy1_in_frame", 32'(req1_ready), 32'd0);
            tick();
        end
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_tx"}, 32'(TX), 32'd1);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        idle_check("reset");
        chk("reset_rdy0", 32'(req0_ready), 32'd0);
        chk("reset_rdy1", 32'(req1_ready), 32'd0);
        resetn = 1'b1;
    endtask

    initial begin
        resetn     = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h31;
        req1_valid = 1'b1;
        req1_data  = 8'h32;
        #1;
        repeat (3) tick();
        idle_check("por");
        chk("por_rdy0", 32'(req0_ready), 32'd0);
        chk("por_rdy1", 32'(req1_ready), 32'd0);

        // Contention straight out of reset: req0 first, req1 exactly 100 cycles later
        resetn = 1'b1;
        #1;
        chk("cont_rdy0", 32'(req0_ready), 32'd1);
        chk("cont_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        frame_check(8'h31, 2'b01, 0, 100);
        chk("b2b_busy", 32'(busy), 32'd0);
        chk("b2b_rdy1", 32'(req1_ready), 32'd1);
        chk("b2b_tx", 32'(TX), 32'd1);
        tick();
        req1_valid = 1'b0;
        frame_check(8'h32, 2'b10, 0, 100);
        idle_check("after_b2b");

        // Lone req0 sends 8'h55
        req0_valid = 1'b1;
        req0_data  = 8'h55;
        #1;
        chk("solo_rdy0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        frame_check(8'h55, 2'b01, 0, 100);
        idle_check("after_55");

        // Four contended frames alternate grants from a fresh pointer
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 8'hA5;
        req1_valid = 1'b1;
        req1_data  = 8'h3C;
        hold_en    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d_rdy0", k), 32'(req0_ready), 32'((k % 2) == 0));
            chk($sformatf("rr%0d_rdy1", k), 32'(req1_ready), 32'((k % 2) == 1));
            tick();
            frame_check(((k % 2) == 0) ? 8'hA5 : 8'h3C, ((k % 2) == 0) ? 2'b01 : 2'b10, 0, 100);
        end
        hold_en    = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        idle_check("after_rr");

        // Reset 35 cycles into a frame of 8'h00 aborts it; next frame starts fresh
        req0_valid = 1'b1;
        req0_data  = 8'h00;
        #1;
        chk("abort_rdy0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        frame_check(8'h00, 2'b01, 0, 35);
        resetn = 1'b0;
        tick();
        idle_check("abort");
        resetn = 1'b1;
        tick();
        idle_check("abort_no_resend");
        req0_valid = 1'b1;
        req0_data  = 8'hC3;
        #1;
        chk("fresh_rdy0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        frame_check(8'hC3, 2'b01, 0, 100);
        idle_check("after_fresh");

        // req1 pulsed for one cycle mid-frame is ignored
        req0_valid = 1'b1;
        req0_data  = 8'h5A;
        #1;
        chk("pulse_rdy0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        frame_check(8'h5A, 2'b01, 0, 20);
        req1_valid = 1'b1;
        req1_data  = 8'h77;
        #1;
        chk("pulse_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        frame_check(8'h5A, 2'b01, 21, 79);
        for (int i = 0; i < 5; i++) begin
            idle_check($sformatf("no_frame%0d", i));
            tick();
        end

        // Pointer unchanged by the ignored pulse or by a withdrawn request: req1 wins
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("ptr_rdy0", 32'(req0_ready), 32'd0);
        chk("ptr_rdy1", 32'(req1_ready), 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        idle_check("withdrawn");
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("ptr2_rdy0", 32'(req0_ready), 32'd0);
        chk("ptr2_rdy1", 32'(req1_ready), 32'd1);

        // Data changed right after acceptance does not alter the frame
        req0_valid = 1'b0;
        req1_data  = 8'h0F;
        #1;
        chk("late_rdy1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        req1_data  = 8'hFF;
        frame_check(8'h0F, 2'b10, 0, 100);
        idle_check("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
